// File: rtl/regs.sv
// Architectural integer register file (x0..x31) for the three-stage RV32 core.
//
// Write-back from EX lands on the rising clock edge; the two ID read ports are
// combinational and see a same-cycle write through a bypass. A pending-write
// scoreboard tracks registers that an issued instruction will still write; a
// read of such a register raises stall_o until its write-back arrives. A debug
// port reads the raw array, and wb_count_o counts accepted write-backs.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rd_addr_i/rd_data_i/rd_wen_i    write-back from EX
//   reg{1,2}_raddr_i, reg{1,2}_re_i ID read addresses and "operand used" flags
//   reg{1,2}_rdata_o                ID read data (with write bypass)
//   issue_rd_addr_i, issue_wen_i    destination of the instruction leaving ID
//   stall_o                         RAW hazard, ID must hold
//   dbg_raddr_i, dbg_rdata_o        debug read port (no bypass)
//   wb_count_o                      count of accepted write-backs (wraps)
module regs #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] rd_data_i,
  input  logic            rd_wen_i,
  input  logic [AW-1:0]   reg1_raddr_i,
  input  logic            reg1_re_i,
  input  logic [AW-1:0]   reg2_raddr_i,
  input  logic            reg2_re_i,
  output logic [XLEN-1:0] reg1_rdata_o,
  output logic [XLEN-1:0] reg2_rdata_o,
  input  logic [AW-1:0]   issue_rd_addr_i,
  input  logic            issue_wen_i,
  output logic            stall_o,
  input  logic [AW-1:0]   dbg_raddr_i,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic [31:0]     wb_count_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic [31:0]      wb_count_q;
  logic             hazard1, hazard2;

  // Zero for x0, bypassed write-back data when it targets the same register,
  // otherwise the stored value.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    if (addr == '0) begin
      return '0;
    end else if (rd_wen_i && (rd_addr_i == addr)) begin
      return rd_data_i;
    end else begin
      return regs_q[addr];
    end
  endfunction

  always_comb begin
    reg1_rdata_o = read_port(reg1_raddr_i);
    reg2_rdata_o = read_port(reg2_raddr_i);
    dbg_rdata_o  = (dbg_raddr_i == '0) ? '0 : regs_q[dbg_raddr_i];
  end

  // A register being written back this cycle is covered by the bypass.
  always_comb begin
    hazard1 = reg1_re_i & pending_q[reg1_raddr_i] &
              ~(rd_wen_i & (rd_addr_i == reg1_raddr_i));
    hazard2 = reg2_re_i & pending_q[reg2_raddr_i] &
              ~(rd_wen_i & (rd_addr_i == reg2_raddr_i));
    stall_o = hazard1 | hazard2;
  end

  // Clear first, then set, so a same-cycle set on the same rd wins: the newer
  // instruction owns the register.
  always_comb begin
    pending_d = pending_q;
    if (rd_wen_i) begin
      pending_d[rd_addr_i] = 1'b0;
    end
    if (issue_wen_i && (issue_rd_addr_i != '0) && !stall_o) begin
      pending_d[issue_rd_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      pending_q  <= '0;
      wb_count_q <= '0;
    end else begin
      if (rd_wen_i && (rd_addr_i != '0)) begin
        regs_q[rd_addr_i] <= rd_data_i;
      end
      pending_q <= pending_d;
      // Counts every accepted write-back, x0 included.
      if (rd_wen_i) begin
        wb_count_q <= wb_count_q + 32'd1;
      end
    end
  end

  assign wb_count_o = wb_count_q;

endmodule

// File: tb/tb_regs.sv
// Directed self-checking bench for regs: reset state, bypass, x0 handling,
// scoreboard stall/clear, set-wins-over-clear, counter wrap, async reset.
module tb_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        rd_wen_i;
  logic [4:0]  reg1_raddr_i, reg2_raddr_i;
  logic        reg1_re_i, reg2_re_i;
  logic [31:0] reg1_rdata_o, reg2_rdata_o;
  logic [4:0]  issue_rd_addr_i;
  logic        issue_wen_i;
  logic        stall_o;
  logic [4:0]  dbg_raddr_i;
  logic [31:0] dbg_rdata_o;
  logic [31:0] wb_count_o;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  regs dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rd_addr_i       (rd_addr_i),
    .rd_data_i       (rd_data_i),
    .rd_wen_i        (rd_wen_i),
    .reg1_raddr_i    (reg1_raddr_i),
    .reg1_re_i       (reg1_re_i),
    .reg2_raddr_i    (reg2_raddr_i),
    .reg2_re_i       (reg2_re_i),
    .reg1_rdata_o    (reg1_rdata_o),
    .reg2_rdata_o    (reg2_rdata_o),
    .issue_rd_addr_i (issue_rd_addr_i),
    .issue_wen_i     (issue_wen_i),
    .stall_o         (stall_o),
    .dbg_raddr_i     (dbg_raddr_i),
    .dbg_rdata_o     (dbg_rdata_o),
    .wb_count_o      (wb_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr_i = '0; rd_data_i = '0; rd_wen_i = 1'b0;
    reg1_raddr_i = '0; reg2_raddr_i = '0; reg1_re_i = 1'b0; reg2_re_i = 1'b0;
    issue_rd_addr_i = '0; issue_wen_i = 1'b0; dbg_raddr_i = '0;
    #12 rst_n = 1'b1;
    tick();

    // Reset state on every address.
    for (int i = 0; i < 32; i++) begin
      reg1_raddr_i = 5'(i); reg2_raddr_i = 5'(i); dbg_raddr_i = 5'(i);
      #1;
      check($sformatf("rst_r1_x%0d", i), reg1_rdata_o, 32'h0);
      check($sformatf("rst_r2_x%0d", i), reg2_rdata_o, 32'h0);
      check($sformatf("rst_dbg_x%0d", i), dbg_rdata_o, 32'h0);
    end
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_count", wb_count_o, 32'h0);

    // Write x5 with same-cycle bypass on port 1.
    tick();
    rd_wen_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'hDEADBEEF;
    reg1_raddr_i = 5'd5; dbg_raddr_i = 5'd5;
    #1;
    check("bypass_r1_x5", reg1_rdata_o, 32'hDEADBEEF);
    check("dbg_x5_before", dbg_rdata_o, 32'h0);
    tick();
    rd_wen_i = 1'b0;
    #1;
    check("dbg_x5_after", dbg_rdata_o, 32'hDEADBEEF);
    check("r1_x5_after", reg1_rdata_o, 32'hDEADBEEF);
    check("count_1", wb_count_o, 32'd1);

    // Write to x0 is discarded but counted.
    rd_wen_i = 1'b1; rd_addr_i = 5'd0; rd_data_i = 32'h12345678;
    reg1_raddr_i = 5'd0; reg2_raddr_i = 5'd0; dbg_raddr_i = 5'd0;
    #1;
    check("x0_r1_during", reg1_rdata_o, 32'h0);
    check("x0_r2_during", reg2_rdata_o, 32'h0);
    tick();
    rd_wen_i = 1'b0;
    #1;
    check("x0_r1_after", reg1_rdata_o, 32'h0);
    check("x0_r2_after", reg2_rdata_o, 32'h0);
    check("x0_dbg_after", dbg_rdata_o, 32'h0);
    check("count_2", wb_count_o, 32'd2);

    // Issue rd=7, then RAW on port 2.
    issue_wen_i = 1'b1; issue_rd_addr_i = 5'd7;
    tick();
    issue_wen_i = 1'b0;
    reg2_raddr_i = 5'd7; reg2_re_i = 1'b1;
    #1;
    check("stall_x7", 32'(stall_o), 32'h1);
    reg2_re_i = 1'b0;
    #1;
    check("nostall_x7_re0", 32'(stall_o), 32'h0);
    reg2_re_i = 1'b1; rd_wen_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'h55;
    #1;
    check("nostall_x7_wb", 32'(stall_o), 32'h0);
    check("bypass_r2_x7", reg2_rdata_o, 32'h55);
    tick();
    rd_wen_i = 1'b0;
    #1;
    check("x7_cleared", 32'(stall_o), 32'h0);
    check("r2_x7_after", reg2_rdata_o, 32'h55);
    check("count_3", wb_count_o, 32'd3);
    reg2_re_i = 1'b0;

    // Set and clear of x9 in one cycle: set wins.
    issue_wen_i = 1'b1; issue_rd_addr_i = 5'd9;
    rd_wen_i = 1'b1; rd_addr_i = 5'd9; rd_data_i = 32'h99;
    tick();
    issue_wen_i = 1'b0; rd_wen_i = 1'b0;
    reg1_raddr_i = 5'd9; reg1_re_i = 1'b1;
    #1;
    check("stall_x9_a", 32'(stall_o), 32'h1);
    // Issue while stalled is ignored.
    issue_wen_i = 1'b1; issue_rd_addr_i = 5'd11;
    tick();
    issue_wen_i = 1'b0;
    #1;
    check("stall_x9_b", 32'(stall_o), 32'h1);
    rd_wen_i = 1'b1; rd_addr_i = 5'd9; rd_data_i = 32'hAA;
    #1;
    check("nostall_x9_wb", 32'(stall_o), 32'h0);
    check("bypass_r1_x9", reg1_rdata_o, 32'hAA);
    tick();
    rd_wen_i = 1'b0;
    #1;
    check("x9_cleared", 32'(stall_o), 32'h0);
    check("count_5", wb_count_o, 32'd5);
    reg1_re_i = 1'b0;
    reg2_raddr_i = 5'd11; reg2_re_i = 1'b1;
    #1;
    check("x11_not_set", 32'(stall_o), 32'h0);
    reg2_re_i = 1'b0;

    // Counter wrap.
    force dut.wb_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wb_count_q;
    #1;
    check("count_forced", wb_count_o, 32'hFFFFFFFF);
    rd_wen_i = 1'b1; rd_addr_i = 5'd4; rd_data_i = 32'h44;
    tick();
    rd_wen_i = 1'b0;
    #1;
    check("count_wrap", wb_count_o, 32'h0);

    // Asynchronous reset mid-cycle with pending bits and live registers.
    issue_wen_i = 1'b1; issue_rd_addr_i = 5'd12;
    tick();
    issue_wen_i = 1'b0;
    reg1_raddr_i = 5'd12; reg1_re_i = 1'b1; dbg_raddr_i = 5'd4; reg2_raddr_i = 5'd5;
    #1;
    check("stall_x12", 32'(stall_o), 32'h1);
    check("dbg_x4_live", dbg_rdata_o, 32'h44);
    rd_wen_i = 1'b1; rd_addr_i = 5'd4; rd_data_i = 32'h77;
    #1;
    rst_n = 1'b0;
    #1;
    rd_wen_i = 1'b0;
    #1;
    check("arst_stall", 32'(stall_o), 32'h0);
    check("arst_dbg_x4", dbg_rdata_o, 32'h0);
    check("arst_r2_x5", reg2_rdata_o, 32'h0);
    check("arst_count", wb_count_o, 32'h0);
    // Write presented while reset is held is discarded.
    rd_wen_i = 1'b1; rd_addr_i = 5'd4; rd_data_i = 32'h77;
    tick();
    rd_wen_i = 1'b0;
    rst_n = 1'b1;
    #1;
    check("arst_dbg_x4_held", dbg_rdata_o, 32'h0);
    check("arst_count_held", wb_count_o, 32'h0);
    check("arst_stall_after", 32'(stall_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
